apb_alu_slave: RTL and testbench

APB completer that exposes a small ALU as five memory-mapped 32-bit registers. It sits on the shared APB bus opposite APB_master, selected by its own PSEL line. It accepts operand and opcode writes and runs a multi-cycle ALU operation. Results and flags are returned on reads, and the block inserts wait states when a result read arrives while the ALU is still busy.

---
 rtl/apb_alu_pkg.sv | 42 ++++
 rtl/apb_alu_slave_if.sv | 31 +++
 rtl/apb_alu_slave_alu_core.sv | 134 +++++++++++++
 rtl/apb_alu_slave.sv | 166 ++++++++++++++++
 tb/tb_apb_alu_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_alu_pkg.sv
// Shared register map, opcodes, FSM states and STATUS bit positions for the APB ALU completer.
// Latency: none (declarations only); backpressure: n/a.
package apb_alu_pkg;

  localparam logic [4:0] OFF_OPA    = 5'h00;
  localparam logic [4:0] OFF_OPB    = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_RESULT = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam int CTRL_START_BIT = 8;

  localparam int STATUS_W = 5;
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_CARRY = 2;
  localparam int ST_ZERO  = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_WAIT   = 2'd3
  } apb_state_e;

  function automatic logic addr_error(input logic [4:0] off);
    return (off[1:0] != 2'b00) || (off > OFF_STATUS);
  endfunction

endpackage

// File: rtl/apb_alu_slave_if.sv
// APB bus bundle between the master and the ALU completer; i_PSTRB exists only with APB_PSTRB_EN.
// Latency: none (wires only); backpressure: carried by o_PREADY.
interface apb_alu_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_PSEL;
  logic                  i_PENABLE;
  logic                  i_PWRITE;
  logic [ADDR_WIDTH-1:0] i_PADDR;
  logic [DATA_WIDTH-1:0] i_PWDATA;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] i_PSTRB;
`endif
  logic [DATA_WIDTH-1:0] o_PRDATA;
  logic                  o_PREADY;
  logic                  o_PSLVERR;

`ifdef APB_PSTRB_EN
  modport master (output i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PSTRB,
                  input  o_PRDATA, o_PREADY, o_PSLVERR);
  modport slave  (input  i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PSTRB,
                  output o_PRDATA, o_PREADY, o_PSLVERR);
`else
  modport master (output i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
                  input  o_PRDATA, o_PREADY, o_PSLVERR);
  modport slave  (input  i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
                  output o_PRDATA, o_PREADY, o_PSLVERR);
`endif

endinterface

// File: rtl/apb_alu_slave_alu_core.sv
// Multi-cycle ALU: latches operands on start, counts ALU_LAT cycles, then commits result/flags and sets done.
// Latency: ALU_LAT cycles start->result; backpressure: none, caller must not start while busy.
module alu_core
  import apb_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_LAT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  alu_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_nxt_o,
  output logic [STATUS_W-1:0]   status_nxt_o
);
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int MSB   = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  alu_op_e               op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] diff, res;
  logic                  res_c, res_v;

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = a_q - b_q;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        res   = sum[MSB:0];
        res_c = sum[DATA_WIDTH];
        res_v = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res   = diff;
        res_c = a_q < b_q;
        res_v = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_SHL:  res = a_q << b_q[SH_W-1:0];
      OP_SHR:  res = a_q >> b_q[SH_W-1:0];
      OP_MUL:  res = a_q * b_q;
      default: res = '0;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      op_d   = op_i;
      cnt_d  = CNT_LOAD;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        result_d = res;
        carry_d  = res_c;
        zero_d   = (res == '0);
        ovf_d    = res_v;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Readers see next-state values so a read in the completion cycle returns the finished result.
  always_comb begin
    status_nxt_o           = '0;
    status_nxt_o[ST_BUSY]  = busy_d;
    status_nxt_o[ST_DONE]  = done_d;
    status_nxt_o[ST_CARRY] = carry_d;
    status_nxt_o[ST_ZERO]  = zero_d;
    status_nxt_o[ST_OVF]   = ovf_d;
  end

  assign result_nxt_o = result_d;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: rtl/apb_alu_slave.sv
// APB completer exposing OPA/OPB/CTRL/RESULT/STATUS of a multi-cycle ALU; APB_PSTRB_EN adds byte strobes.
// Latency: zero wait states, except RESULT read while busy stalls PREADY until completion; PSEL drop aborts a stall.
module apb_alu_slave
  import apb_alu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ALU_LAT    = 4
) (
  input  logic           i_PCLK,
  input  logic           i_PRESETn,
  apb_alu_slave_if.slave apb,
  output logic           o_IRQ
);
  apb_state_e            state_q, state_d, phase;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [4:0]            off_q, off_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  alu_op_e               opcode_q, opcode_d;

  logic [4:0]            off;
  logic                  req_err, wait_needed, commit, start, start_lane;
  logic [DATA_WIDTH-1:0] rd_data, wmask;
  logic                  alu_busy, alu_done;
  logic [DATA_WIDTH-1:0] alu_result_nxt;
  logic [STATUS_W-1:0]   alu_status_nxt;
  logic                  unused_addr;

  assign off         = apb.i_PADDR[4:0];
  assign unused_addr = ^apb.i_PADDR[ADDR_WIDTH-1:5];

`ifdef APB_PSTRB_EN
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      wmask[i*8 +: 8] = {8{apb.i_PSTRB[i]}};
    end
  end
  assign start_lane = apb.i_PSTRB[CTRL_START_BIT / 8];
`else
  assign wmask      = '1;
  assign start_lane = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_OPA:    rd_data = opa_q;
      OFF_OPB:    rd_data = opb_q;
      OFF_CTRL:   rd_data = DATA_WIDTH'(opcode_q);
      OFF_RESULT: rd_data = alu_result_nxt;
      OFF_STATUS: rd_data = DATA_WIDTH'(alu_status_nxt);
      default:    rd_data = '0;
    endcase
  end

  assign req_err = addr_error(off)
                || (apb.i_PWRITE && (off == OFF_RESULT || off == OFF_STATUS))
                || (apb.i_PWRITE && alu_busy && (off == OFF_OPA || off == OFF_OPB || off == OFF_CTRL));
  assign wait_needed = !apb.i_PWRITE && (off == OFF_RESULT) && alu_status_nxt[ST_BUSY];

  // SETUP is the bus setup cycle itself: decoding there lets the registered response land in the first ACCESS cycle.
  always_comb begin
    phase = state_q;
    if (state_q != S_WAIT && apb.i_PSEL && !apb.i_PENABLE) phase = S_SETUP;
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    off_d     = off_q;
    wr_d      = wr_q;
    case (phase)
      S_SETUP: begin
        off_d = off;
        wr_d  = apb.i_PWRITE && !req_err;
        if (req_err) begin
          state_d   = S_ACCESS;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (wait_needed) begin
          state_d = S_WAIT;
        end else begin
          state_d  = S_ACCESS;
          pready_d = 1'b1;
          if (!apb.i_PWRITE) prdata_d = rd_data;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      S_WAIT: begin
        if (!apb.i_PSEL) begin
          state_d = S_IDLE;
        end else if (!alu_status_nxt[ST_BUSY]) begin
          state_d  = S_ACCESS;
          pready_d = 1'b1;
          prdata_d = alu_result_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = (state_q == S_ACCESS) && wr_q && apb.i_PSEL && apb.i_PENABLE;
  assign start  = commit && (off_q == OFF_CTRL) && apb.i_PWDATA[CTRL_START_BIT] && start_lane;

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    opcode_d = opcode_q;
    if (commit) begin
      case (off_q)
        OFF_OPA:  opa_d = (opa_q & ~wmask) | (apb.i_PWDATA & wmask);
        OFF_OPB:  opb_d = (opb_q & ~wmask) | (apb.i_PWDATA & wmask);
        OFF_CTRL: opcode_d = alu_op_e'((opcode_q & ~wmask[2:0]) | (apb.i_PWDATA[2:0] & wmask[2:0]));
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q   <= S_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      off_q     <= '0;
      wr_q      <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      opcode_q  <= OP_ADD;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opcode_q  <= opcode_d;
    end
  end

  alu_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALU_LAT    (ALU_LAT)
  ) u_alu (
    .clk_i        (i_PCLK),
    .rst_ni       (i_PRESETn),
    .start_i      (start),
    .op_i         (opcode_d),
    .a_i          (opa_q),
    .b_i          (opb_q),
    .busy_o       (alu_busy),
    .done_o       (alu_done),
    .result_nxt_o (alu_result_nxt),
    .status_nxt_o (alu_status_nxt)
  );

  assign apb.o_PREADY  = pready_q;
  assign apb.o_PSLVERR = pslverr_q;
  assign apb.o_PRDATA  = prdata_q;
  assign o_IRQ         = alu_done;

endmodule

// File: tb/tb_apb_alu_slave.sv
// Directed bench for apb_alu_slave: vector table of APB transfers plus hand-written stall, abort and reset sequences.
// Latency/backpressure are observed through counted PREADY-low cycles.
module tb_apb_alu_slave;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  logic irq;
  int   n_tests;
  int   n_fail;

  apb_alu_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_alu_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ALU_LAT    (LAT)
  ) dut (
    .i_PCLK    (clk),
    .i_PRESETn (rst_n),
    .apb       (bus),
    .o_IRQ     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_waits = exp_waits;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One APB transfer; returns right after the completing edge so a following call is back-to-back.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    logic got;
    bus.i_PSEL    = 1'b1;
    bus.i_PENABLE = 1'b0;
    bus.i_PWRITE  = wr;
    bus.i_PADDR   = addr;
    bus.i_PWDATA  = wdata;
    @(posedge clk); #1;
    bus.i_PENABLE = 1'b1;
    waits = 0;
    rdata = '0;
    err   = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (bus.o_PREADY) begin
        rdata = bus.o_PRDATA;
        err   = bus.o_PSLVERR;
        got   = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: addr %h got no PREADY, expected PREADY within 64 cycles", addr);
    end
    @(posedge clk); #1;
    bus.i_PSEL    = 1'b0;
    bus.i_PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Setup + first access cycle of a read, left open so the caller can stall or abort it.
  task automatic open_read(input logic [31:0] addr);
    bus.i_PSEL    = 1'b1;
    bus.i_PENABLE = 1'b0;
    bus.i_PWRITE  = 1'b0;
    bus.i_PADDR   = addr;
    @(posedge clk); #1;
    bus.i_PENABLE = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp, input int exp_waits);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(1'b0, addr, '0, rd, err, w);
    check({name, "_data"}, rd, exp);
    check({name, "_err"}, {31'b0, err}, 32'h0);
    check({name, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(1'b1, addr, data, rd, err, w);
    check("wr_err", {31'b0, err}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.i_PSEL    = 1'b0;
    bus.i_PENABLE = 1'b0;
    bus.i_PWRITE  = 1'b0;
    bus.i_PADDR   = '0;
    bus.i_PWDATA  = '0;
`ifdef APB_PSTRB_EN
    bus.i_PSTRB   = '1;
`endif

    // addr, wdata, expected read data, expected error, expected PREADY-low access cycles
    add(1, 32'h00, 32'hFFFF_FFFF, 0, 0, 0);
    add(1, 32'h04, 32'h1, 0, 0, 0);
    add(1, 32'h08, 32'h100, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h0, 0, LAT-1);          // setup cycle + LAT-1 stalled cycles = LAT
    add(0, 32'h10, 0, 32'h0E, 0, 0);
    add(0, 32'h08, 0, 32'h0, 0, 0);
    add(1, 32'h00, 32'h7FFF_FFFF, 0, 0, 0);
    add(1, 32'h08, 32'h101, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h7FFF_FFFE, 0, LAT-1);
    add(0, 32'h10, 0, 32'h02, 0, 0);
    add(1, 32'h08, 32'h100, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h8000_0000, 0, LAT-1);
    add(0, 32'h10, 0, 32'h12, 0, 0);
    add(1, 32'h0C, 32'h1234, 0, 1, 0);
    add(0, 32'h14, 0, 0, 1, 0);
    add(0, 32'h02, 0, 0, 1, 0);
    add(1, 32'h10, 32'hFF, 0, 1, 0);
    add(0, 32'h1C, 0, 0, 1, 0);
    add(0, 32'h0C, 0, 32'h8000_0000, 0, 0);
    add(0, 32'h00, 0, 32'h7FFF_FFFF, 0, 0);
    add(1, 32'h00, 32'h3, 0, 0, 0);
    add(1, 32'h04, 32'h5, 0, 0, 0);
    add(1, 32'h08, 32'h107, 0, 0, 0);
    add(1, 32'h00, 32'h9, 0, 1, 0);              // busy: rejected
    add(0, 32'h00, 0, 32'h3, 0, 0);
    add(0, 32'h0C, 0, 32'hF, 0, 0);              // MUL finished during the two prior transfers
    add(0, 32'h10, 0, 32'h02, 0, 0);
    add(0, 32'h00, 0, 32'h3, 0, 0);
    add(1, 32'h00, 32'hF0F0_1234, 0, 0, 0);
    add(1, 32'h04, 32'h24, 0, 0, 0);             // shift amount = 4
    add(1, 32'h08, 32'h105, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h0F01_2340, 0, LAT-1);
    add(1, 32'h08, 32'h106, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h0F0F_0123, 0, LAT-1);
    add(1, 32'h08, 32'h104, 0, 0, 0);
    add(0, 32'h0C, 0, 32'hF0F0_1210, 0, LAT-1);
    add(1, 32'h08, 32'h102, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h0000_0024, 0, LAT-1);
    add(1, 32'h08, 32'h103, 0, 0, 0);
    add(0, 32'h0C, 0, 32'hF0F0_1234, 0, LAT-1);
    add(1, 32'h00, 32'h1, 0, 0, 0);
    add(1, 32'h04, 32'h2, 0, 0, 0);
    add(1, 32'h08, 32'h101, 0, 0, 0);
    add(0, 32'h0C, 0, 32'hFFFF_FFFF, 0, LAT-1);
    add(0, 32'h10, 0, 32'h06, 0, 0);
    add(1, 32'h08, 32'h005, 0, 0, 0);            // opcode only, no START
    add(0, 32'h08, 0, 32'h5, 0, 0);
    add(0, 32'h10, 0, 32'h06, 0, 0);
    add(1, 32'h04, 32'h0, 0, 0, 0);
    add(1, 32'h08, 32'h102, 0, 0, 0);
    add(0, 32'h0C, 0, 32'h0, 0, LAT-1);
    add(0, 32'h10, 0, 32'h0A, 0, 0);

    #1;
    check("rst_pready", {31'b0, bus.o_PREADY}, 32'h0);
    check("rst_pslverr", {31'b0, bus.o_PSLVERR}, 32'h0);
    check("rst_prdata", bus.o_PRDATA, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    rd_chk("por_status", 32'h10, 32'h0, 0);
    rd_chk("por_opa", 32'h00, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, w);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_waits", i), 32'(w), 32'(vecs[i].exp_waits));
      if (!vecs[i].wr || vecs[i].exp_err)
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    check("irq_after_done", {31'b0, irq}, 32'h1);

    // STATUS read one cycle before and exactly in the completion cycle
    wr_ok(32'h00, 32'h1);
    wr_ok(32'h04, 32'h2);
    wr_ok(32'h08, 32'h100);
    idle(LAT + 1);
    wr_ok(32'h08, 32'h100);
    idle(LAT - 2);
    rd_chk("status_busy", 32'h10, 32'h01, 0);
    wr_ok(32'h08, 32'h100);
    idle(LAT - 1);
    rd_chk("status_complete_cycle", 32'h10, 32'h02, 0);

    // PSEL dropped during a stalled RESULT read
    wr_ok(32'h08, 32'h107);
    open_read(32'h0C);
    check("abort_stall_pready", {31'b0, bus.o_PREADY}, 32'h0);
    @(posedge clk); #1;
    bus.i_PSEL    = 1'b0;
    bus.i_PENABLE = 1'b0;
    idle(LAT + 2);
    @(negedge clk);
    check("abort_idle_pready", {31'b0, bus.o_PREADY}, 32'h0);
    check("abort_idle_pslverr", {31'b0, bus.o_PSLVERR}, 32'h0);
    idle(1);
    rd_chk("abort_result", 32'h0C, 32'h2, 0);

    // reset while a RESULT read is stalled
    wr_ok(32'h08, 32'h100);
    open_read(32'h0C);
    check("wait_pready_low", {31'b0, bus.o_PREADY}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("wait_rst_pready", {31'b0, bus.o_PREADY}, 32'h0);
    check("wait_rst_irq", {31'b0, irq}, 32'h0);
    bus.i_PSEL    = 1'b0;
    bus.i_PENABLE = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rd_chk("wait_rst_status", 32'h10, 32'h0, 0);
    rd_chk("wait_rst_result", 32'h0C, 32'h0, 0);
    wr_ok(32'h00, 32'h7);
    rd_chk("wait_rst_opa", 32'h00, 32'h7, 0);

    // reset while the ALU is busy
    wr_ok(32'h08, 32'h100);
    rd_chk("busy_status", 32'h10, 32'h01, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("busy_rst_pready", {31'b0, bus.o_PREADY}, 32'h0);
    check("busy_rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(LAT + 1);
    check("busy_rst_irq_after", {31'b0, irq}, 32'h0);
    rd_chk("busy_rst_status", 32'h10, 32'h0, 0);
    rd_chk("busy_rst_opa", 32'h00, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
